// File: rtl/diff_pkg.sv
// Shared types and helpers for the pipelined multi-lane subtractor.
// Holds the result-mode encoding and the popcount used by the underflow counter.
package diff_pkg;

  typedef enum logic [1:0] {
    DM_WRAP = 2'd0,
    DM_SAT  = 2'd1,
    DM_ABS  = 2'd2,
    DM_REV  = 2'd3
  } diff_mode_e;

  // Widest borrow vector the popcount helper accepts; callers zero-extend.
  localparam int POP_MAX = 256;
  localparam int POP_W   = 9;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] pc;
    pc = {POP_W{1'b0}};
    for (int i = 0; i < POP_MAX; i++) begin
      pc = pc + {{(POP_W-1){1'b0}}, v[i]};
    end
    return pc;
  endfunction

endpackage

// File: rtl/diff_lane.sv
// Single-lane combinational subtractor with four result modes.
// The borrow is the MSB of the (WIDTH+1)-bit difference a-b.
module diff_lane
  import diff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  diff_mode_e       mode,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0]   ab_s;
  logic [WIDTH-1:0] ba_s;

  assign ab_s   = {1'b0, a} - {1'b0, b};
  assign ba_s   = b - a;
  assign borrow = ab_s[WIDTH];

  // Result selection per mode.
  always_comb begin
    diff = ab_s[WIDTH-1:0];
    case (mode)
      DM_WRAP: diff = ab_s[WIDTH-1:0];
      DM_SAT:  diff = borrow ? {WIDTH{1'b0}} : ab_s[WIDTH-1:0];
      DM_ABS:  diff = borrow ? ba_s : ab_s[WIDTH-1:0];
      DM_REV:  diff = ba_s;
      default: diff = ab_s[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/diff_pipe_unit.sv
// Two-stage valid/ready pipelined multi-lane subtractor with per-lane borrow
// flags and a saturating count of borrowing lanes over delivered results.
module diff_pipe_unit
  import diff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LANES = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] diff,
  output logic [LANES-1:0]       borrow,
  output logic [CNT_W-1:0]       uflow_cnt,
  input  logic                   clr_cnt
);

  localparam int LW    = LANES * WIDTH;
  localparam int SUM_W = CNT_W + POP_W;

  logic             v1_q, v1_d;
  logic [LW-1:0]    a1_q, a1_d;
  logic [LW-1:0]    b1_q, b1_d;
  diff_mode_e       m1_q, m1_d;
  logic             v2_q, v2_d;
  logic [LW-1:0]    diff_q, diff_d;
  logic [LANES-1:0] borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rdy1_s, rdy2_s, out_fire_s;
  logic [LW-1:0]    lane_diff_s;
  logic [LANES-1:0] lane_borrow_s;
  logic [POP_MAX-1:0] borrow_ext_s;
  logic [SUM_W-1:0] sum_s;

  assign rdy2_s     = !v2_q || out_ready;
  assign rdy1_s     = !v1_q || rdy2_s;
  assign in_ready   = rst_n && rdy1_s;
  assign out_fire_s = v2_q && out_ready;

  assign out_valid  = v2_q;
  assign diff       = diff_q;
  assign borrow     = borrow_q;
  assign uflow_cnt  = cnt_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    diff_lane #(.WIDTH(WIDTH)) u_lane (
      .a      (a1_q[g*WIDTH +: WIDTH]),
      .b      (b1_q[g*WIDTH +: WIDTH]),
      .mode   (m1_q),
      .diff   (lane_diff_s[g*WIDTH +: WIDTH]),
      .borrow (lane_borrow_s[g])
    );
  end

  // Next-state for both pipeline stages and the underflow counter.
  always_comb begin
    v1_d     = v1_q;
    a1_d     = a1_q;
    b1_d     = b1_q;
    m1_d     = m1_q;
    v2_d     = v2_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    if (rdy1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        a1_d = a;
        b1_d = b;
        m1_d = diff_mode_e'(mode);
      end else begin
        a1_d = a1_q;
      end
    end else begin
      v1_d = v1_q;
    end

    // Result registers only reload when a new result arrives, so they stay
    // stable while stalled and keep the last value once drained.
    if (rdy2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        diff_d   = lane_diff_s;
        borrow_d = lane_borrow_s;
      end else begin
        diff_d   = diff_q;
      end
    end else begin
      v2_d = v2_q;
    end

    borrow_ext_s                = {POP_MAX{1'b0}};
    borrow_ext_s[LANES-1:0]     = borrow_q;
    sum_s = {{POP_W{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, popcount(borrow_ext_s)};

    if (clr_cnt) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (out_fire_s) begin
      if (sum_s > {{POP_W{1'b0}}, {CNT_W{1'b1}}}) begin
        cnt_d = {CNT_W{1'b1}};
      end else begin
        cnt_d = sum_s[CNT_W-1:0];
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      a1_q     <= {LW{1'b0}};
      b1_q     <= {LW{1'b0}};
      m1_q     <= DM_WRAP;
      v2_q     <= 1'b0;
      diff_q   <= {LW{1'b0}};
      borrow_q <= {LANES{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      m1_q     <= m1_d;
      v2_q     <= v2_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_diff_pipe_unit.sv
// Self-checking bench for diff_pipe_unit (WIDTH=4, LANES=4, CNT_W=4): directed
// cases plus randomized traffic against a transaction-level reference model.
module tb_diff_pipe_unit;

  localparam int W  = 4;
  localparam int L  = 4;
  localparam int CW = 4;
  localparam int LW = W * L;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] a, b;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] diff;
  logic [L-1:0]  borrow;
  logic [CW-1:0] uflow_cnt;
  logic          clr_cnt;

  always #5 clk = ~clk;

  diff_pipe_unit #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .uflow_cnt(uflow_cnt), .clr_cnt(clr_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO of expected results with their age in clock edges.
  logic [LW-1:0] q_d[$];
  logic [L-1:0]  q_b[$];
  int            q_age[$];
  int            m_cnt = 0;
  bit            last_rst = 1'b0;
  bit            last_in_fire;

  logic          obs_ov;
  logic [LW-1:0] obs_diff;
  logic [L-1:0]  obs_br;
  logic [CW-1:0] obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lane_ref(input int x, input int y, input int m);
    case (m)
      0:       return (x - y + 16) % 16;
      1:       return (x < y) ? 0 : x - y;
      2:       return (x < y) ? y - x : x - y;
      default: return (y - x + 16) % 16;
    endcase
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cyc(input logic iv, input logic [LW-1:0] ia, input logic [LW-1:0] ib,
                     input logic [1:0] im, input logic ordy, input logic clr, input logic rst);
    bit exp_ov, exp_ir, in_fire, out_fire;
    logic [LW-1:0] ed;
    logic [L-1:0]  eb;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; mode = im;
    out_ready = ordy; clr_cnt = clr; rst_n = !rst;
    #1;
    exp_ov = (q_d.size() > 0) && (q_age[0] >= 2);
    exp_ir = (q_d.size() < 2) || ordy;
    obs_ov = out_valid; obs_diff = diff; obs_br = borrow; obs_cnt = uflow_cnt;
    if (rst) chk("in_ready_rst", {31'd0, in_ready}, 32'd0);
    else     chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      chk("diff", {16'd0, diff}, {16'd0, q_d[0]});
      chk("borrow", {28'd0, borrow}, {28'd0, q_b[0]});
    end
    if (last_rst) begin
      chk("diff_after_rst", {16'd0, diff}, 32'd0);
      chk("borrow_after_rst", {28'd0, borrow}, 32'd0);
    end
    chk("uflow_cnt", {28'd0, uflow_cnt}, m_cnt);
    in_fire  = iv && exp_ir && !rst;
    out_fire = exp_ov && ordy && !rst;
    for (int i = 0; i < L; i++) begin
      ed[i*W +: W] = 4'(lane_ref(int'(ia[i*W +: W]), int'(ib[i*W +: W]), int'(im)));
      eb[i] = ia[i*W +: W] < ib[i*W +: W];
    end
    @(posedge clk);
    if (rst) begin
      q_d.delete(); q_b.delete(); q_age.delete();
      m_cnt = 0;
    end else begin
      if (clr) m_cnt = 0;
      else if (out_fire) m_cnt = (m_cnt + $countones(q_b[0]) > CMAX) ? CMAX : m_cnt + $countones(q_b[0]);
      if (out_fire) begin
        void'(q_d.pop_front()); void'(q_b.pop_front()); void'(q_age.pop_front());
      end
      foreach (q_age[i]) q_age[i]++;
      if (in_fire) begin
        q_d.push_back(ed); q_b.push_back(eb); q_age.push_back(1);
      end
    end
    last_rst = rst;
    last_in_fire = in_fire;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 16'h0000, 16'h0000, 2'd0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    bit ordy_pat[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int sent;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 2'd0;
    out_ready = 1'b1; clr_cnt = 1'b0;

    cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b0, 1'b1);

    // Basic WRAP with exact 2-cycle latency.
    cyc(1'b1, 16'h000E, 16'h0007, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("t1_lat1_ov", {31'd0, obs_ov}, 32'd0);
    idle(1'b1);
    chk("t1_lat2_ov", {31'd0, obs_ov}, 32'd1);
    chk("t1_diff", {28'd0, obs_diff[3:0]}, 32'd7);
    cyc(1'b1, 16'h0002, 16'h0003, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t1b_diff", {28'd0, obs_diff[3:0]}, 32'd15);
    chk("t1b_borrow", {31'd0, obs_br[0]}, 32'd1);
    idle(1'b1);
    chk("t1b_cnt", {28'd0, obs_cnt}, 32'd1);

    // All modes: lane0 2-3, other lanes 9-9.
    for (int m = 0; m < 4; m++) cyc(1'b1, 16'h9992, 16'h9993, 2'(m), 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    // Independent lanes.
    cyc(1'b1, 16'h0F37, 16'h1E52, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t3_diff", {16'd0, obs_diff}, 32'h0000F1E5);
    chk("t3_borrow", {28'd0, obs_br}, 32'h0000000A);

    // Backpressure stream of 5 under a fixed out_ready pattern.
    sent = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(sent < 5, 16'(($urandom & 32'hFFFF)), 16'(($urandom & 32'hFFFF)),
          2'($urandom_range(0, 3)), (k < 12) ? ordy_pat[k] : 1'b1, 1'b0, 1'b0);
      if (last_in_fire) sent++;
    end
    chk("t4_sent", sent, 32'd5);

    // Counter saturation and clear-wins.
    cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 16'h0000, 16'hFFFF, 2'd1, 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    chk("t5_sat", {28'd0, obs_cnt}, CMAX);
    cyc(1'b1, 16'h0000, 16'hFFFF, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("t5_clr", {28'd0, obs_cnt}, 32'd0);

    // Reset with two transactions in flight.
    cyc(1'b1, 16'h0000, 16'h1111, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 16'h3333, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("t6_ov", {31'd0, obs_ov}, 32'd0);
    chk("t6_cnt", {28'd0, obs_cnt}, 32'd0);
    cyc(1'b1, 16'h000E, 16'h0007, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t6_diff", {28'd0, obs_diff[3:0]}, 32'd7);

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      logic [LW-1:0] ra, rb;
      ra = 16'($urandom & 32'hFFFF);
      rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom & 32'hFFFF);
      cyc($urandom_range(0, 3) != 0, ra, rb, 2'($urandom_range(0, 3)),
          $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 99) == 0);
    end
    repeat (4) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/diff_pipe_unit.md
Name: diff_pipe_unit

Overview:
Parametrised, multi-lane, pipelined subtractor for the arithmetic datapath. It generalises the single 4-bit difference block in four ways:
- width and lane count are parameters
- four result modes are selectable per transaction
- a valid/ready handshake with full backpressure is added
- a per-lane borrow flag and a saturating underflow event counter are added

It sits between an operand source, such as a register file or FIFO, and a downstream result consumer.

Parameters:
WIDTH, 4, bit width of each lane operand and result
LANES, 1, number of independent subtraction lanes (>=1)
CNT_W, 8, width of underflow event counter

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  unit can accept operands this cycle
a  input  LANES*WIDTH  minuend, lane i at [i*WIDTH +: WIDTH]
b  input  LANES*WIDTH  subtrahend, same packing
mode  input  2  result mode, captured with operands
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
diff  output  LANES*WIDTH  per-lane result, same packing as a
borrow  output  LANES  per-lane flag, 1 when a_i < b_i (unsigned)
uflow_cnt  output  CNT_W  count of lanes that borrowed, over all accepted results
clr_cnt  input  1  synchronous clear of uflow_cnt

Behaviour:
- One clock. Reset is synchronous and active-low: all state is updated only on rising clk, and rst_n=0 is sampled at the edge.
- Reset values:
  - out_valid=0, diff=0, borrow=0, uflow_cnt=0, internal stage valids=0.
  - in_ready is driven 0 while rst_n=0.
- Reset mid-operation: all in-flight transactions are discarded. No partial result appears after reset.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline has two register stages:
  - S1 registers a, b, mode.
  - S2 registers diff and borrow.
  - Latency is exactly 2 cycles from input transfer to out_valid=1 when out_ready is held 1.
- Stall rules (combinational chain):
  - rdy2 = !v2 || out_ready
  - rdy1 = !v1 || rdy2
  - in_ready = rdy1 (when rst_n=1)
  - Throughput is one transaction per cycle under continuous out_ready=1.
  - No transaction is lost or duplicated under any out_ready pattern.
  - diff and borrow hold stable while out_valid=1 and out_ready=0.
- Per-lane arithmetic (unsigned, WIDTH bits, computed in WIDTH+1 bits):
  - mode 00 WRAP: diff = (a-b) mod 2^WIDTH
  - mode 01 SAT: diff = (a<b) ? 0 : a-b
  - mode 10 ABS: diff = |a-b|
  - mode 11 REV: diff = (b-a) mod 2^WIDTH
  - borrow_i = (a_i < b_i) in every mode. a_i == b_i gives diff 0 and borrow 0 in all modes.
- Lanes are fully independent. There is no carry or borrow between lanes.
- uflow_cnt:
  - On each output transfer, it adds popcount(borrow) and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 sets it to 0. Clear wins over a same-cycle increment, and that increment is dropped.
- Mode values outside the encoding do not exist, because all four are defined.

Decomposition:
- Package diff_pkg holds:
  - typedef enum logic [1:0] diff_mode_e {DM_WRAP, DM_SAT, DM_ABS, DM_REV}
  - a popcount function used by the counter
- Sub-module diff_lane: purely combinational single-lane compute. Inputs a, b, mode; outputs diff, borrow; parameter WIDTH.
  - Instantiated LANES times by generate.
  - Lives between S1 and S2.
- Handshake, pipeline registers and counter live in diff_pipe_unit.

Test Plan:
1. WIDTH=4, LANES=1, WRAP, out_ready=1: a=14,b=7 -> diff=7, borrow=0, exactly 2 cycles after transfer. Then a=2,b=3 -> diff=15, borrow=1, uflow_cnt=1.
2. Modes with a=2,b=3: SAT -> 0; ABS -> 1; REV -> 1; borrow=1 each. With a=9,b=9 -> diff=0, borrow=0 in all modes.
3. LANES=4, WIDTH=4, WRAP: a=0x0F37, b=0x1E52 (lane0 7-2, lane1 3-5, lane2 15-14, lane3 0-1) -> diff=0xF1E5, borrow=4'b1010, uflow_cnt +=2.
4. Backpressure: stream 5 transactions back-to-back with out_ready pattern 1,0,0,1,0,1,1,... -> all 5 results emerge in order, unchanged while stalled. in_ready drops to 0 only when both stages are full and out_ready=0.
5. Counter: CNT_W=2, accept 5 borrowing results -> uflow_cnt sticks at 3. Assert clr_cnt in the same cycle as a borrowing output transfer -> uflow_cnt=0 next cycle.
6. Reset: with 2 transactions in flight, drive rst_n=0 for one edge -> out_valid=0, diff=0, borrow=0, uflow_cnt=0, in_ready=0 during reset. No stale result afterwards; a new a=14,b=7 WRAP gives diff=7 after 2 cycles.
